// File: rtl/arb4_rr_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
interface arb4_rr_if;
    logic [3:0] i_req;      // bit k = requester k, level-sensitive
    logic [3:0] o_gnt;      // one-hot grant
    logic [1:0] o_gnt_idx;  // binary index of the owner
    logic       o_gnt_vld;  // any grant active

    // Requester side drives requests and observes the grant.
    modport master (output i_req, input o_gnt, o_gnt_idx, o_gnt_vld);
    // Arbiter side observes requests and drives the grant.
    modport slave  (input i_req, output o_gnt, o_gnt_idx, o_gnt_vld);
endinterface

// File: rtl/arb4_rr.sv
// Four-way round-robin arbiter with a per-owner hold limit under contention.
// Outputs are decoded straight from flops, so they change only at clock edges.
module arb4_rr #(
    parameter int unsigned HOLD_MAX = 8   // 1..15
) (
    input  logic      i_clk,
    input  logic      i_rst,
    arb4_rr_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;     // first requester searched next time
    logic [1:0] idx_q, idx_d;     // current owner
    logic [3:0] cnt_q, cnt_d;     // consecutive cycles held by the owner

    logic [3:0] own_mask;
    logic [3:0] cand;
    logic [1:0] pos;
    logic [1:0] win;
    logic       win_vld;

    // Round-robin search over every requester except the current owner,
    // starting at ptr; scanning downward lets the nearest hit win last.
    always_comb begin
        own_mask = (state_q == GRANT) ? (4'b0001 << idx_q) : 4'b0000;
        cand     = bus.i_req & ~own_mask;
        pos      = ptr_q;
        win      = 2'd0;
        win_vld  = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            pos = ptr_q + 2'(k);
            if (cand[pos]) begin
                win     = pos;
                win_vld = 1'b1;
            end
        end
    end

    // State, owner, pointer and hold-counter registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: grant on demand, hand over on release or when the hold
    // limit is hit while someone else waits, otherwise keep the owner.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANT;
                    idx_d   = win;
                    ptr_d   = win + 2'd1;
                    cnt_d   = 4'd1;
                end
            end
            GRANT: begin
                if (!bus.i_req[idx_q] || cnt_q == HOLD_LIM) begin
                    if (win_vld) begin
                        // Hand over in the same edge: no idle bubble.
                        idx_d = win;
                        ptr_d = win + 2'd1;
                        cnt_d = 4'd1;
                    end else if (!bus.i_req[idx_q]) begin
                        state_d = IDLE;
                        idx_d   = 2'd0;
                        cnt_d   = 4'd0;
                    end
                    // Otherwise: uncontended at the limit, hold with cnt saturated.
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: index is cleared in IDLE, so decode gated by valid is one-hot or zero.
    always_comb begin
        bus.o_gnt_vld = (state_q == GRANT);
        bus.o_gnt_idx = idx_q;
        bus.o_gnt     = (state_q == GRANT) ? (4'b0001 << idx_q) : 4'b0000;
    end
endmodule

// File: tb/tb_arb4_rr.sv
// Bench for arb4_rr: directed vector table, hand-written corner sequences,
// then randomized requests against a behavioural round-robin model.
module tb_arb4_rr;
    localparam int HOLD_MAX = 8;

    logic clk;
    logic rst;
    arb4_rr_if bus();

    arb4_rr #(.HOLD_MAX(HOLD_MAX)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: owner (-1 = none), last winner (search starts after it) and
    // how many cycles the owner has held so far (unbounded).
    int m_owner = -1;
    int m_last  = 3;
    int m_run   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
    } vec_t;

    vec_t tbl[9];

    function automatic int pick(logic [3:0] c, int last);
        for (int k = 1; k <= 4; k++) begin
            if (c[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_step(logic [3:0] req, logic r);
        int w;
        logic [3:0] others;
        if (r) begin
            m_owner = -1; m_last = 3; m_run = 0;
        end else if (m_owner < 0) begin
            w = pick(req, m_last);
            if (w >= 0) begin m_owner = w; m_last = w; m_run = 1; end
        end else begin
            others = req & ~(4'b0001 << m_owner);
            if (!req[m_owner] || (m_run >= HOLD_MAX && others != 4'b0000)) begin
                w = pick(others, m_last);
                if (w >= 0) begin m_owner = w; m_last = w; m_run = 1; end
                else begin m_owner = -1; m_run = 0; end
            end else begin
                m_run++;
            end
        end
    endtask

    task automatic check(string name, logic [3:0] act, logic [3:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_out(string name, logic [3:0] g, logic [1:0] i, logic v);
        check({name, ".gnt"}, bus.o_gnt, g);
        check({name, ".idx"}, {2'b00, bus.o_gnt_idx}, {2'b00, i});
        check({name, ".vld"}, {3'b000, bus.o_gnt_vld}, {3'b000, v});
    endtask

    // Apply inputs, take one edge, advance the model, settle before sampling.
    task automatic tick(logic [3:0] req, logic r);
        bus.i_req = req;
        rst       = r;
        @(posedge clk);
        model_step(req, r);
        #1;
    endtask

    task automatic check_model(string name);
        logic [3:0] g;
        logic [1:0] i;
        g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        i = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        check_out(name, g, i, m_owner >= 0);
    endtask

    initial begin
        logic [3:0] rreq;
        logic       rrst;

        // Reset with all requesting, release, then round-robin with each
        // owner dropping its request for one cycle after being granted.
        tbl[0] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
        tbl[1] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0};
        tbl[2] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1};
        tbl[3] = '{1'b0, 4'b1110, 4'b0010, 2'd1, 1'b1};
        tbl[4] = '{1'b0, 4'b1101, 4'b0100, 2'd2, 1'b1};
        tbl[5] = '{1'b0, 4'b1011, 4'b1000, 2'd3, 1'b1};
        tbl[6] = '{1'b0, 4'b0111, 4'b0001, 2'd0, 1'b1};
        tbl[7] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0};
        tbl[8] = '{1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0};

        bus.i_req = 4'b0000;
        rst       = 1'b1;
        #2;
        for (int n = 0; n < 9; n++) begin
            tick(tbl[n].req, tbl[n].rst);
            check_out($sformatf("tbl%0d", n), tbl[n].gnt, tbl[n].idx, tbl[n].vld);
        end

        // Hold limit: two constant requesters alternate every HOLD_MAX cycles.
        for (int n = 0; n < HOLD_MAX; n++) begin
            tick(4'b0011, 1'b0);
            check_out("hold_a", 4'b0001, 2'd0, 1'b1);
        end
        for (int n = 0; n < HOLD_MAX; n++) begin
            tick(4'b0011, 1'b0);
            check_out("hold_b", 4'b0010, 2'd1, 1'b1);
        end
        tick(4'b0011, 1'b0);
        check_out("hold_c", 4'b0001, 2'd0, 1'b1);

        // Uncontended owner keeps the grant well past the hold limit.
        tick(4'b0000, 1'b1);
        for (int n = 0; n < 30; n++) begin
            tick(4'b0100, 1'b0);
            check_out("uncont", 4'b0100, 2'd2, 1'b1);
        end
        tick(4'b0000, 1'b0);
        check_out("uncont_drop", 4'b0000, 2'd0, 1'b0);

        // Pointer wrap: 3 -> 0 -> 2.
        tick(4'b0000, 1'b1);
        tick(4'b1000, 1'b0);
        check_out("wrap_3", 4'b1000, 2'd3, 1'b1);
        tick(4'b0101, 1'b0);
        check_out("wrap_0", 4'b0001, 2'd0, 1'b1);
        tick(4'b0100, 1'b0);
        check_out("wrap_2", 4'b0100, 2'd2, 1'b1);

        // Reset mid-grant drops the owner, then it is granted again.
        tick(4'b0000, 1'b1);
        tick(4'b0010, 1'b0);
        check_out("mid_own", 4'b0010, 2'd1, 1'b1);
        tick(4'b0010, 1'b1);
        check_out("mid_rst", 4'b0000, 2'd0, 1'b0);
        tick(4'b0010, 1'b0);
        check_out("mid_regnt", 4'b0010, 2'd1, 1'b1);

        // Random phase: sticky requests with occasional flips and rare resets.
        rreq = 4'b0000;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) rreq[b] = ~rreq[b];
            end
            rrst = ($urandom_range(0, 249) == 0);
            tick(rreq, rrst);
            check_model("rand");
            check("rand.onehot", {1'b0, 3'($countones(bus.o_gnt))},
                  (m_owner >= 0) ? 4'd1 : 4'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
